seq_multiplier: RTL and testbench



---
 rtl/seq_multiplier.sv | 91 +++++++++
 tb/tb_seq_multiplier.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH-bit operands, 2*WIDTH-bit product, one multiplier bit per cycle.
// Optional SEQ_MULTIPLIER_EARLY_TERM_EN finishes as soon as no set multiplier bits remain.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               signed_r;
  logic [CNT_W-1:0]   cnt;
  logic [PW-1:0]      acc, acc_nxt, pp;
  logic               last, finish, accept;

  function automatic logic [PW-1:0] part_prod(input logic [WIDTH-1:0] mcand,
                                              input logic sgn,
                                              input logic bit_v,
                                              input logic [CNT_W-1:0] sh);
    logic signed [PW-1:0] ext;
    ext = sgn ? {{WIDTH{mcand[WIDTH-1]}}, mcand} : {{WIDTH{1'b0}}, mcand};
    return bit_v ? (ext << sh) : '0;
  endfunction

  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign pp     = part_prod(a_r, signed_r, b_r[cnt], cnt);
  // The multiplier sign bit weighs -2^(WIDTH-1) in two's complement.
  assign acc_nxt = (signed_r && last) ? (acc - pp) : (acc + pp);
  assign accept  = start && ready;

`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
  logic [WIDTH-1:0] upper;
  assign upper  = (b_r >> cnt) >> 1;
  assign finish = last || (upper == '0);
`else
  assign finish = last;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (finish) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state != S_RUN);
    done  = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      signed_r <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      result   <= '0;
    end else if (accept) begin
      a_r      <= a;
      b_r      <= b;
      signed_r <= signed_mode;
      acc      <= '0;
      cnt      <= '0;
    end else if (state == S_RUN) begin
      acc <= acc_nxt;
      cnt <= cnt + CNT_W'(1);
      if (finish) result <= acc_nxt;
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (WIDTH=8): directed vectors, monitor checks product and latency.
module tb_seq_multiplier;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        ready, done;
  logic [15:0] result;

  seq_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .ready(ready), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    int          lat;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0, acc_total = 0, done_cnt = 0, n_ops = 0;
  int   checks = 0, failures = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, expv);
    end
  endtask

  // Accept edges are timestamped so the monitor can measure start-to-done latency.
  always @(posedge clk) begin
    cyc++;
    if (arst_n && start && ready) begin
      acc_q.push_back(cyc);
      acc_total++;
    end
  end

  always @(negedge clk) begin
    if (arst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 result=0x%0h", result);
      end else begin
        exp_t e;
        int   t0;
        e  = exp_q.pop_front();
        t0 = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
        chk(e.name, int'(result), int'(e.res));
        chk({e.name, "_lat"}, cyc - t0, e.lat);
      end
      done_cnt++;
    end
  end

  function automatic int pick_lat(input int lf, input int le);
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    return le;
`else
    return lf;
`endif
  endfunction

  task automatic push_exp(input logic [15:0] er, input int lf, input int le, input string nm);
    exp_t e;
    e.res  = er;
    e.lat  = pick_lat(lf, le);
    e.name = nm;
    exp_q.push_back(e);
    n_ops++;
  endtask

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic sm,
                       input logic [15:0] er, input int lf, input int le,
                       input string nm, input bit push);
    int k = 0;
    @(negedge clk);
    while (!ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk({nm, "_ready_timeout"}, 0, 1);
    a = ia; b = ib; signed_mode = sm; start = 1'b1;
    if (push) push_exp(er, lf, le, nm);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_cnt < target && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #12;
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    @(negedge clk);
    arst_n = 1'b1;

    // Unsigned max operands, with ready low for the whole run.
    issue(8'hFF, 8'hFF, 1'b0, 16'hFE01, 8, 8, "u_ff_ff", 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk("run_ready_low", int'(ready), 0);
      @(negedge clk);
    end
    wait_done(n_ops);

    issue(8'hFD, 8'h05, 1'b1, 16'hFFF1, 8, 3, "s_fd_05", 1'b1);
    wait_done(n_ops);
    issue(8'hFD, 8'h05, 1'b0, 16'h04F1, 8, 3, "u_fd_05", 1'b1);
    wait_done(n_ops);
    issue(8'h80, 8'h80, 1'b1, 16'h4000, 8, 8, "s_80_80", 1'b1);
    wait_done(n_ops);
    issue(8'h7F, 8'h80, 1'b1, 16'hC080, 8, 8, "s_7f_80", 1'b1);
    wait_done(n_ops);
    issue(8'h5A, 8'h00, 1'b0, 16'h0000, 8, 1, "u_b0", 1'b1);
    wait_done(n_ops);
    issue(8'h11, 8'h03, 1'b0, 16'h0033, 8, 2, "u_b3", 1'b1);
    wait_done(n_ops);

    // A start pulse while busy must be dropped.
    issue(8'h0F, 8'h0F, 1'b0, 16'h00E1, 8, 4, "busy_first", 1'b1);
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; signed_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n_ops);
    repeat (12) @(negedge clk);

    // Back-to-back operations with start held high.
    begin
      logic [7:0]  va[3] = '{8'hFF, 8'h12, 8'h81};
      logic [7:0]  vb[3] = '{8'hFF, 8'h34, 8'h7F};
      logic        vs[3] = '{1'b1, 1'b0, 1'b1};
      logic [15:0] vr[3] = '{16'h0001, 16'h03A8, 16'hC0FF};
      int          ve[3] = '{8, 6, 7};
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        int n;
        int k;
        a = va[i]; b = vb[i]; signed_mode = vs[i]; start = 1'b1;
        push_exp(vr[i], 8, ve[i], $sformatf("b2b_%0d", i));
        n = acc_total;
        k = 0;
        while (acc_total == n && k < 60) begin
          @(negedge clk);
          k++;
        end
        if (acc_total == n) chk("b2b_accept_timeout", 0, 1);
      end
      start = 1'b0;
      wait_done(n_ops);
    end

    // Asynchronous reset mid-run aborts without a done.
    issue(8'h33, 8'hC3, 1'b0, 16'h0000, 8, 8, "abort", 1'b0);
    repeat (2) @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    chk("abort_ready", int'(ready), 1);
    chk("abort_result", int'(result), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (14) @(negedge clk);
    acc_q.delete();

    chk("queue_empty", exp_q.size(), 0);
    chk("done_total", done_cnt, n_ops);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
